// File: rtl/pc_fetch_ctrl_pkg.sv
// Shared definitions for the fetch-stage PC sequencer: state encodings and
// default reset/exception addresses.
package pc_fetch_ctrl_pkg;

  typedef enum logic [1:0] {
    StRun   = 2'd0,
    StHold  = 2'd1,
    StRedir = 2'd2
  } fetch_state_e;

  localparam logic [31:0] DefResetPc   = 32'h0000_3000;
  localparam logic [31:0] DefExcVector = 32'h0000_4180;
  localparam logic [31:0] DefImBase    = 32'h0000_3000;
  localparam logic [31:0] DefImSize    = 32'h0000_1000;

endpackage

// File: rtl/pc_fetch_ctrl_if.sv
// Fetch-control bundle: hazard/NPC/CP0 requests in, registered PC and status out.
interface pc_fetch_ctrl_if;

  logic        stall;
  logic [31:0] npc;
  logic        d_is_brjmp;
  logic        exc_req;
  logic        eret_req;
  logic [31:0] epc;
  logic [31:0] pc;
  logic        f_bd;
  logic        f_adel;
  logic [1:0]  state;

  modport master (
    output stall, npc, d_is_brjmp, exc_req, eret_req, epc,
    input  pc, f_bd, f_adel, state
  );

  modport slave (
    input  stall, npc, d_is_brjmp, exc_req, eret_req, epc,
    output pc, f_bd, f_adel, state
  );

endinterface

// File: rtl/pc_fetch_ctrl_range_chk.sv
// Combinational AdEL detector: flags a fetch address that is misaligned or
// outside the instruction memory window.
module pc_fetch_ctrl_range_chk
  import pc_fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] IM_BASE = DefImBase,
  parameter logic [31:0] IM_SIZE = DefImSize
) (
  input  logic [31:0] pc,
  output logic        f_adel
);

  // 33-bit limit so a window ending at the top of the address space cannot wrap.
  localparam logic [32:0] ImLimit = {1'b0, IM_BASE} + {1'b0, IM_SIZE};

  logic misaligned;
  logic below;
  logic above;

  always_comb begin
    misaligned = |pc[1:0];
    below      = pc < IM_BASE;
    above      = {1'b0, pc} >= ImLimit;
    f_adel     = misaligned | below | above;
  end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Fetch-stage PC sequencer: owns PC and the delay-slot flag, selecting between
// NPC, exception vector and ERET return address under hazard stalls.
module pc_fetch_ctrl
  import pc_fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DefResetPc,
  parameter logic [31:0] EXC_VECTOR = DefExcVector,
  parameter logic [31:0] IM_BASE    = DefImBase,
  parameter logic [31:0] IM_SIZE    = DefImSize
) (
  input logic             clk,
  input logic             reset,
  pc_fetch_ctrl_if.slave  bus
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic         bd_q, bd_d;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= StRun;
      pc_q    <= RESET_PC;
      bd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      bd_q    <= bd_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    bd_d    = bd_q;
    case (state_q)
      StRun, StHold: begin
        if (bus.exc_req) begin
          pc_d    = EXC_VECTOR;
          bd_d    = 1'b0;
          state_d = StRedir;
        end else if (bus.eret_req) begin
          pc_d    = bus.epc;
          bd_d    = 1'b0;
          state_d = StRedir;
        end else if (bus.stall) begin
          state_d = StHold;
        end else begin
          pc_d    = bus.npc;
          bd_d    = bus.d_is_brjmp;
          state_d = StRun;
        end
      end
      StRedir: begin
        // Pipeline was just flushed, so a stall here refers to stale state.
        if (bus.exc_req) begin
          pc_d    = EXC_VECTOR;
          bd_d    = 1'b0;
        end else if (bus.eret_req) begin
          pc_d    = bus.epc;
          bd_d    = 1'b0;
        end else begin
          pc_d    = bus.npc;
          bd_d    = bus.d_is_brjmp;
          state_d = StRun;
        end
      end
      default: state_d = StRun;
    endcase
  end

  pc_fetch_ctrl_range_chk #(
    .IM_BASE (IM_BASE),
    .IM_SIZE (IM_SIZE)
  ) u_range_chk (
    .pc     (pc_q),
    .f_adel (bus.f_adel)
  );

  assign bus.pc    = pc_q;
  assign bus.f_bd  = bd_q;
  assign bus.state = state_q;

endmodule
